vip_sobel_edge_detector: RTL and testbench
==========================================

VIP_SOBEL_EDGE_DETECTOR -- requirements
Module: vip_sobel_edge_detector

Interface
REQ-001 The block SHALL have parameter CNT_W, default 20, width of the per-frame edge-pixel counter.
REQ-002 The block SHALL have these ports, one per line (name  direction  width  meaning):
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- matrix_frame_vsync  in  1  frame sync from the 3x3 matrix stage, active-high pulse between frames.
- matrix_frame_href  in  1  line-valid.
- matrix_frame_clken  in  1  pixel-valid.
- matrix_p11..matrix_p33  in  8 each  3x3 window, p11 top-left, p33 bottom-right.
- threshold  in  8  edge threshold.
- post_frame_vsync  out  1  delayed vsync.
- post_frame_href  out  1  delayed href.
- post_frame_clken  out  1  delayed clken.
- post_img_mag  out  8  saturated gradient magnitude.
- post_img_bit  out  1  edge flag.
- edge_count  out  CNT_W  edge pixels in last completed frame.
- frame_done  out  1  one-cycle pulse when edge_count updates.

Function
REQ-003 Gradients SHALL be Gx = (p13+2*p23+p33) - (p11+2*p21+p31) and Gy = (p11+2*p12+p13) - (p31+2*p32+p33).
REQ-004 Stage 1 SHALL register the four partial sums unsigned, 10 bits each (max 1020), no overflow.
REQ-005 Stage 2 SHALL register |Gx| and |Gy| as 10-bit unsigned absolute differences (larger minus smaller).
REQ-006 Stage 3 SHALL register mag = |Gx|+|Gy| in 11 bits (max 2040).
REQ-007 Stage 4 SHALL register post_img_mag = min(mag, 255) and post_img_bit = 1 iff mag > thr_q (strict).
REQ-008 The data pipeline SHALL advance every clock, independent of clken.
REQ-009 vsync, href and clken SHALL each be delayed by a 4-deep shift register, so outputs align with their data; latency is exactly 4 cycles.
REQ-010 When the stage-4-aligned href is 0, post_img_mag and post_img_bit SHALL be registered as 0.
REQ-011 thr_q SHALL capture threshold on the rising edge of matrix_frame_vsync only; mid-frame threshold changes SHALL NOT affect the current frame.
REQ-012 Pixel counting:
- The accumulator SHALL increment when post_frame_href, post_frame_clken and post_img_bit are all 1.
- It SHALL saturate at 2^CNT_W-1.
REQ-013 On the rising edge of post_frame_vsync:
- edge_count SHALL load the accumulator value plus any coincident increment (saturated).
- The accumulator SHALL clear to 0.
- frame_done SHALL pulse high for exactly one cycle.
REQ-014 Before the first post_frame_vsync rising edge, edge_count SHALL stay 0 and frame_done SHALL stay 0.
REQ-015 Sustained vsync high SHALL produce only one frame_done pulse per rising edge.

Reset
REQ-016 On rst_n low, the following SHALL clear to 0 asynchronously:
- all pipeline registers;
- all sync delay registers;
- thr_q, accumulator, edge_count, frame_done;
- the vsync edge-detect registers.
REQ-017 After rst_n rises, outputs SHALL stay 0 until valid input propagates 4 cycles; a reset mid-frame discards that frame's partial count.

Verification
REQ-018 All p = 100, threshold 0, href = clken = 1 -> 4 cycles later post_img_mag = 0, post_img_bit = 0.
REQ-019 Vertical edge: left column 0, middle 0, right column 255, thr_q = 128 -> mag 1020 saturates, post_img_mag = 255, post_img_bit = 1.
REQ-020 p13 = p23 = p33 = 10, others 0 -> Gx = 40, Gy = 0, post_img_mag = 40; bit = 0 with thr_q = 40; bit = 1 with thr_q = 39.
REQ-021 Threshold change from 40 to 0 mid-frame -> bit unchanged until after the next input vsync rising edge.
REQ-022 Frame of 8x4 pixels with 5 edge pixels, then a vsync pulse -> frame_done pulses once, edge_count = 5, accumulator restarts at 0.
REQ-023 Toggle clken and href in random patterns -> post_* sync signals equal the inputs delayed by exactly 4 cycles; an rst_n pulse mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/vip_sobel_edge_detector.sv
// rtl/vip_sobel_edge_detector.sv - 4-stage Sobel gradient magnitude with edge flag and per-frame edge count
module vip_sobel_edge_detector #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             matrix_frame_vsync,
  input  logic             matrix_frame_href,
  input  logic             matrix_frame_clken,
  input  logic [7:0]       matrix_p11,
  input  logic [7:0]       matrix_p12,
  input  logic [7:0]       matrix_p13,
  input  logic [7:0]       matrix_p21,
  input  logic [7:0]       matrix_p22,
  input  logic [7:0]       matrix_p23,
  input  logic [7:0]       matrix_p31,
  input  logic [7:0]       matrix_p32,
  input  logic [7:0]       matrix_p33,
  input  logic [7:0]       threshold,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic [7:0]       post_img_mag,
  output logic             post_img_bit,
  output logic [CNT_W-1:0] edge_count,
  output logic             frame_done
);

  logic [9:0]       s1_gx_p, s1_gx_n, s1_gy_p, s1_gy_n;
  logic [9:0]       s2_gx, s2_gy;
  logic [10:0]      s3_mag;
  logic [3:0]       vsync_dly, href_dly, clken_dly;
  logic [7:0]       thr_q;
  logic             vsync_in_q, vsync_out_q;
  logic [CNT_W-1:0] acc, acc_next;
  logic             pix_edge, frame_rise;

  // Partial sums stay unsigned; the sign is resolved by the absolute difference in stage 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_gx_p <= '0;
      s1_gx_n <= '0;
      s1_gy_p <= '0;
      s1_gy_n <= '0;
      s2_gx   <= '0;
      s2_gy   <= '0;
      s3_mag  <= '0;
    end else begin
      s1_gx_p <= {2'b00, matrix_p13} + {1'b0, matrix_p23, 1'b0} + {2'b00, matrix_p33};
      s1_gx_n <= {2'b00, matrix_p11} + {1'b0, matrix_p21, 1'b0} + {2'b00, matrix_p31};
      s1_gy_p <= {2'b00, matrix_p11} + {1'b0, matrix_p12, 1'b0} + {2'b00, matrix_p13};
      s1_gy_n <= {2'b00, matrix_p31} + {1'b0, matrix_p32, 1'b0} + {2'b00, matrix_p33};
      s2_gx   <= (s1_gx_p >= s1_gx_n) ? (s1_gx_p - s1_gx_n) : (s1_gx_n - s1_gx_p);
      s2_gy   <= (s1_gy_p >= s1_gy_n) ? (s1_gy_p - s1_gy_n) : (s1_gy_n - s1_gy_p);
      s3_mag  <= {1'b0, s2_gx} + {1'b0, s2_gy};
    end
  end

  // href_dly[2] is the href that lines up with the stage-4 register being loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_img_mag <= '0;
      post_img_bit <= 1'b0;
    end else if (href_dly[2]) begin
      post_img_mag <= (s3_mag > 11'd255) ? 8'hff : s3_mag[7:0];
      post_img_bit <= (s3_mag > {3'b000, thr_q});
    end else begin
      post_img_mag <= '0;
      post_img_bit <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_dly <= '0;
      href_dly  <= '0;
      clken_dly <= '0;
    end else begin
      vsync_dly <= {vsync_dly[2:0], matrix_frame_vsync};
      href_dly  <= {href_dly[2:0], matrix_frame_href};
      clken_dly <= {clken_dly[2:0], matrix_frame_clken};
    end
  end

  assign post_frame_vsync = vsync_dly[3];
  assign post_frame_href  = href_dly[3];
  assign post_frame_clken = clken_dly[3];

  // Threshold is frame-stable: sampled only at the start of input vsync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_in_q <= 1'b0;
      thr_q      <= '0;
    end else begin
      vsync_in_q <= matrix_frame_vsync;
      if (matrix_frame_vsync && !vsync_in_q)
        thr_q <= threshold;
    end
  end

  always_comb begin
    pix_edge   = post_frame_href & post_frame_clken & post_img_bit;
    frame_rise = post_frame_vsync & ~vsync_out_q;
    acc_next   = acc;
    if (pix_edge && (acc != {CNT_W{1'b1}}))
      acc_next = acc + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_out_q <= 1'b0;
      acc         <= '0;
      edge_count  <= '0;
      frame_done  <= 1'b0;
    end else begin
      vsync_out_q <= post_frame_vsync;
      frame_done  <= frame_rise;
      if (frame_rise) begin
        edge_count <= acc_next;
        acc        <= '0;
      end else begin
        acc <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_vip_sobel_edge_detector.sv
// tb/tb_vip_sobel_edge_detector.sv - directed self-checking bench for vip_sobel_edge_detector
module tb_vip_sobel_edge_detector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync, href, clken;
  logic [7:0]  p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic [7:0]  threshold;
  logic        post_frame_vsync, post_frame_href, post_frame_clken;
  logic [7:0]  post_img_mag;
  logic        post_img_bit;
  logic [19:0] edge_count;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;
  int fd_cnt;
  logic [2:0] in_h [0:39];

  vip_sobel_edge_detector #(.CNT_W(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .matrix_frame_vsync(vsync), .matrix_frame_href(href), .matrix_frame_clken(clken),
    .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
    .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
    .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
    .threshold(threshold),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken), .post_img_mag(post_img_mag),
    .post_img_bit(post_img_bit), .edge_count(edge_count), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_flat(input logic [7:0] v);
    {p11, p12, p13, p21, p22, p23, p31, p32, p33} = {9{v}};
  endtask

  // Columns: left/middle = a, right = b
  task automatic set_cols(input logic [7:0] a, input logic [7:0] b);
    p11 = a; p12 = a; p21 = a; p22 = a; p31 = a; p32 = a;
    p13 = b; p23 = b; p33 = b;
  endtask

  task automatic vsync_pulse(input logic [7:0] thr);
    threshold = thr;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick(8);
  endtask

  initial begin
    rst_n = 1'b0; vsync = 1'b0; href = 1'b0; clken = 1'b0;
    threshold = 8'd0;
    set_flat(8'd0);
    tick(2);
    chk("rst_mag", post_img_mag, 0);
    chk("rst_bit", post_img_bit, 0);
    chk("rst_sync", {post_frame_vsync, post_frame_href, post_frame_clken}, 0);
    chk("rst_cnt", edge_count, 0);
    rst_n = 1'b1;

    // Flat field at threshold 0
    href = 1'b1; clken = 1'b1;
    set_flat(8'd100);
    tick(4);
    chk("flat_mag", post_img_mag, 0);
    chk("flat_bit", post_img_bit, 0);
    chk("pre_vsync_done", frame_done, 0);
    chk("pre_vsync_cnt", edge_count, 0);

    // Vertical step edge saturates
    href = 1'b0;
    vsync_pulse(8'd128);
    href = 1'b1;
    set_cols(8'd0, 8'd255);
    tick(4);
    chk("vedge_mag", post_img_mag, 255);
    chk("vedge_bit", post_img_bit, 1);

    // Gx = 40 against thresholds 40 and 39
    href = 1'b0;
    vsync_pulse(8'd40);
    href = 1'b1;
    set_cols(8'd0, 8'd10);
    tick(4);
    chk("gx40_mag", post_img_mag, 40);
    chk("gx40_thr40_bit", post_img_bit, 0);
    href = 1'b0;
    vsync_pulse(8'd39);
    href = 1'b1;
    tick(4);
    chk("gx40_thr39_bit", post_img_bit, 1);

    // Mid-frame threshold change waits for next vsync
    href = 1'b0;
    vsync_pulse(8'd40);
    href = 1'b1;
    tick(4);
    chk("thr40_bit", post_img_bit, 0);
    threshold = 8'd0;
    tick(6);
    chk("thr_midframe_bit", post_img_bit, 0);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick(4);
    chk("thr_after_vsync_bit", post_img_bit, 1);

    // 8x4 frame with 5 edge pixels
    href = 1'b0;
    vsync_pulse(8'd128);
    for (int ln = 0; ln < 4; ln++) begin
      for (int c = 0; c < 8; c++) begin
        int idx;
        idx = ln * 8 + c;
        href = 1'b1;
        if (idx == 1 || idx == 11 || idx == 16 || idx == 23 || idx == 29)
          set_cols(8'd0, 8'd255);
        else
          set_flat(8'd50);
        tick();
      end
      href = 1'b0;
      tick(2);
    end
    tick(6);
    vsync = 1'b1;
    fd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) vsync = 1'b0;
      fd_cnt += int'(frame_done);
    end
    chk("frame1_done_pulses", fd_cnt, 1);
    chk("frame1_edge_count", edge_count, 5);

    // Second frame, 2 edges, sustained vsync
    for (int c = 0; c < 8; c++) begin
      href = 1'b1;
      if (c == 2 || c == 6) set_cols(8'd0, 8'd255);
      else set_flat(8'd50);
      tick();
    end
    href = 1'b0;
    tick(6);
    vsync = 1'b1;
    fd_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 2) vsync = 1'b0;
      fd_cnt += int'(frame_done);
    end
    chk("frame2_done_pulses", fd_cnt, 1);
    chk("frame2_edge_count", edge_count, 2);

    // Random sync patterns delayed by exactly 4
    for (int i = 0; i < 40; i++) begin
      in_h[i] = 3'($urandom_range(0, 7));
      {vsync, href, clken} = in_h[i];
      tick();
      if (i >= 3)
        chk("sync_delay", {post_frame_vsync, post_frame_href, post_frame_clken}, in_h[i-3]);
    end

    // Mid-frame asynchronous reset
    vsync = 1'b0; href = 1'b1; clken = 1'b1;
    set_cols(8'd0, 8'd255);
    tick(5);
    chk("pre_rst_mag", post_img_mag, 255);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mag", post_img_mag, 0);
    chk("async_rst_bit", post_img_bit, 0);
    chk("async_rst_sync", {post_frame_vsync, post_frame_href, post_frame_clken}, 0);
    chk("async_rst_cnt", edge_count, 0);
    chk("async_rst_done", frame_done, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_mag_early", post_img_mag, 0);
    tick(2);
    chk("post_rst_mag_late", post_img_mag, 255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
